// File: rtl/mc_control_if.sv
// ---------------------------------------------------------------------------
// mc_control_if -- memory request/acknowledge handshake between the
// multi-cycle controller and the instruction/data memory.
//   mem_req    : access request, held until mem_ready
//   mem_wr_en  : write strobe, qualifies mem_req
//   mem_ready  : memory acknowledge for the current request
// Modports: master = controller side, slave = memory side.
// ---------------------------------------------------------------------------
interface mc_control_if;
    logic mem_req;
    logic mem_wr_en;
    logic mem_ready;

    modport master (output mem_req, output mem_wr_en, input  mem_ready);
    modport slave  (input  mem_req, input  mem_wr_en, output mem_ready);
endinterface

// File: rtl/mc_control.sv
// ---------------------------------------------------------------------------
// mc_control -- multi-cycle MIPS-style control FSM (IF/ID/EX/MEM/WB/ERR).
// Ports:
//   i_clk, i_rst_n      : clock, async active-low reset
//   mem                 : memory handshake (master modport)
//   i_opcode, i_func    : IR fields, latched in ID
//   i_zero              : ALU zero flag, used in EX for BEQ
//   o_ir_ld_en          : load IR
//   o_pc_ld_en/o_pc_sel : PC update strobe / 0 = PC+4, 1 = branch target
//   o_alu_func          : ALU operation
//   o_alu_bin_sel       : 0 = reg B, 1 = immediate
//   o_rf_wr_en          : register-file write
//   o_rf_wr_addr_sel    : 0 = rd, 1 = rt
//   o_rf_wr_data_sel    : 0 = ALU_out, 1 = MEM_out
//   o_state             : current state (debug)
//   o_err               : sticky memory-timeout flag
// ---------------------------------------------------------------------------
module mc_control (
    input  logic         i_clk,
    input  logic         i_rst_n,
    mc_control_if.master mem,
    input  logic [5:0]   i_opcode,
    input  logic [5:0]   i_func,
    input  logic         i_zero,
    output logic         o_ir_ld_en,
    output logic         o_pc_ld_en,
    output logic         o_pc_sel,
    output logic [3:0]   o_alu_func,
    output logic         o_alu_bin_sel,
    output logic         o_rf_wr_en,
    output logic         o_rf_wr_addr_sel,
    output logic         o_rf_wr_data_sel,
    output logic [2:0]   o_state,
    output logic         o_err
);
    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_ERR = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b100000;
    localparam logic [5:0] OP_ADDI  = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b001111;
    localparam logic [5:0] OP_SW    = 6'b011111;
    localparam logic [5:0] OP_BEQ   = 6'b000000;
    localparam logic [5:0] OP_B     = 6'b111111;

    state_t     r_state, w_next;
    logic [5:0] r_op, r_func;
    logic [3:0] r_wait;

    logic w_rtype, w_addi, w_lw, w_sw, w_beq, w_b, w_timeout;
    logic w_mem_req, w_mem_wr_en, w_ir_ld_en, w_pc_ld_en, w_pc_sel;
    logic [3:0] w_alu_func;
    logic w_alu_bin_sel, w_rf_wr_en, w_rf_wr_addr_sel, w_rf_wr_data_sel, w_err;
    logic w_unused;

    // Only the low four Func bits drive the ALU.
    assign w_unused = ^r_func[5:4];

    assign w_rtype   = (r_op == OP_RTYPE);
    assign w_addi    = (r_op == OP_ADDI);
    assign w_lw      = (r_op == OP_LW);
    assign w_sw      = (r_op == OP_SW);
    assign w_beq     = (r_op == OP_BEQ);
    assign w_b       = (r_op == OP_B);
    // Saturated wait with no acknowledge this cycle; an ack on the same cycle wins.
    assign w_timeout = (r_wait == 4'd15) && !mem.mem_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IF;
            r_op    <= '0;
            r_func  <= '0;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_ID) begin
                r_op   <= i_opcode;
                r_func <= i_func;
            end
            if (mem.mem_ready || (w_next != r_state))
                r_wait <= '0;
            else if ((r_state == S_IF) || (r_state == S_MEM))
                r_wait <= r_wait + 4'd1;
        end
    end

    always_comb begin
        w_next           = S_IF;
        w_mem_req        = 1'b0;
        w_mem_wr_en      = 1'b0;
        w_ir_ld_en       = 1'b0;
        w_pc_ld_en       = 1'b0;
        w_pc_sel         = 1'b0;
        w_alu_func       = 4'b0000;
        w_alu_bin_sel    = 1'b0;
        w_rf_wr_en       = 1'b0;
        w_rf_wr_addr_sel = 1'b0;
        w_rf_wr_data_sel = 1'b0;
        w_err            = 1'b0;

        // ALU controls are held through EX/MEM/WB so the datapath result stays stable.
        if ((r_state == S_EX) || (r_state == S_MEM) || (r_state == S_WB)) begin
            if (w_rtype)    w_alu_func = r_func[3:0];
            else if (w_beq) w_alu_func = 4'b0001;
            w_alu_bin_sel = w_addi || w_lw || w_sw;
        end

        case (r_state)
            S_IF: begin
                w_mem_req = 1'b1;
                if (mem.mem_ready) begin
                    w_ir_ld_en = 1'b1;
                    w_next     = S_ID;
                end else begin
                    w_next = w_timeout ? S_ERR : S_IF;
                end
            end
            S_ID: w_next = S_EX;
            S_EX: begin
                if (w_rtype || w_addi)   w_next = S_WB;
                else if (w_lw || w_sw)   w_next = S_MEM;
                else begin
                    // BEQ, B and illegal opcodes all retire here.
                    w_pc_ld_en = 1'b1;
                    w_pc_sel   = w_b || (w_beq && i_zero);
                    w_next     = S_IF;
                end
            end
            S_MEM: begin
                w_mem_req   = 1'b1;
                w_mem_wr_en = w_sw;
                if (mem.mem_ready) begin
                    if (w_lw) begin
                        w_next = S_WB;
                    end else begin
                        w_pc_ld_en = 1'b1;
                        w_next     = S_IF;
                    end
                end else begin
                    w_next = w_timeout ? S_ERR : S_MEM;
                end
            end
            S_WB: begin
                w_rf_wr_en       = 1'b1;
                w_rf_wr_data_sel = w_lw;
                w_rf_wr_addr_sel = !w_rtype;
                w_pc_ld_en       = 1'b1;
                w_next           = S_IF;
            end
            S_ERR: begin
                w_err  = 1'b1;
                w_next = S_ERR;
            end
            default: w_next = S_IF;
        endcase
    end

    // Outputs are forced low while reset is held, even though the state reads IF.
    assign mem.mem_req      = i_rst_n & w_mem_req;
    assign mem.mem_wr_en    = i_rst_n & w_mem_wr_en;
    assign o_ir_ld_en       = i_rst_n & w_ir_ld_en;
    assign o_pc_ld_en       = i_rst_n & w_pc_ld_en;
    assign o_pc_sel         = i_rst_n & w_pc_sel;
    assign o_alu_func       = i_rst_n ? w_alu_func : 4'b0000;
    assign o_alu_bin_sel    = i_rst_n & w_alu_bin_sel;
    assign o_rf_wr_en       = i_rst_n & w_rf_wr_en;
    assign o_rf_wr_addr_sel = i_rst_n & w_rf_wr_addr_sel;
    assign o_rf_wr_data_sel = i_rst_n & w_rf_wr_data_sel;
    assign o_err            = i_rst_n & w_err;
    assign o_state          = r_state;
endmodule
